tinker_prog_loader: RTL and testbench
=====================================

TINKER_PROG_LOADER -- requirements
Module: tinker_prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h2000: byte address of the first image word, equal to the core reset PC.
REQ-002 SHALL have parameter MEM_BYTES, default 524288: memory size in bytes; no write may touch an address at or above it.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start, input, 1: one-cycle pulse that arms a new load.
REQ-006 SHALL have ports in_valid, input, 1; in_data, input, 8; in_last, input, 1: image byte stream; in_last marks the final byte.
REQ-007 SHALL have port in_ready, output, 1: the loader accepts a byte this cycle.
REQ-008 SHALL have ports mem_we, output, 1; mem_addr, output, 64; mem_wdata, output, 64: 8-byte little-endian write request.
REQ-009 SHALL have port mem_ready, input, 1: the memory accepts the write this cycle.
REQ-010 SHALL have ports core_reset, output, 1; done, output, 1; error, output, 1: core_reset is active-high reset to the core.

Function
REQ-011 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE and ERROR.
REQ-012 A byte SHALL transfer on a cycle with in_valid and in_ready both high; in_ready SHALL be 1 only in COLLECT.
REQ-013 Transition rules SHALL be:
- IDLE, DONE or ERROR with start high -> COLLECT; address = BASE_ADDR, byte count = 0, buffer = 0.
- start SHALL be ignored in COLLECT and WRITE.
REQ-014 In COLLECT, the k-th accepted byte of a word (k = 0..7) SHALL be placed in buffer bits [8k+7:8k].
REQ-015 COLLECT -> WRITE SHALL occur on the cycle the 8th byte, or any in_last byte, is accepted; unfilled upper bytes SHALL be zero.
REQ-016 In WRITE, mem_we SHALL be 1 with mem_addr = current address and mem_wdata = buffer, all held stable until mem_ready.
REQ-017 On mem_ready in WRITE:
- address advances by 8 and buffer clears;
- next state is DONE if the word held the last byte, else COLLECT.
REQ-018 Latency from an accepted 8th or last byte to mem_we high SHALL be exactly 1 cycle.
REQ-019 An overflow SHALL send the FSM to ERROR instead of WRITE, with no memory write issued. Overflow is address + 8 > MEM_BYTES at the moment WRITE would be entered.
REQ-020 Output behaviour SHALL be:
- core_reset = 1 in every state except DONE;
- done = 1 only in DONE;
- error = 1 only in ERROR;
- mem_we = 1 only in WRITE.
REQ-021 in_last on the 8th byte of a word SHALL produce one full word and then DONE, with no extra empty write.
REQ-022 An empty image cannot occur, because every image ends with a byte carrying in_last.

Reset
REQ-023 While reset = 0, the FSM SHALL be in IDLE and the following SHALL hold:
- address = BASE_ADDR, buffer = 0, count = 0;
- in_ready = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0;
- core_reset = 1, done = 0, error = 0.
REQ-024 Reset asserted mid-WRITE SHALL drop mem_we immediately; no partial state SHALL survive.

Configuration
REQ-025 Macro LOADER_CSUM_EN defined:
- the in_last byte SHALL be a checksum, not image data, and SHALL never be stored;
- the last word SHALL be written only if the 8-bit sum of all data bytes modulo 256 equals the checksum; otherwise the FSM SHALL go to ERROR without writing;
- an in_last byte that arrives with 0 data bytes pending in the buffer and a matching checksum SHALL go directly to DONE.
REQ-026 Macro LOADER_CSUM_EN undefined: the in_last byte SHALL be ordinary data and no checksum logic SHALL exist.

Structure
REQ-027 A shared package tinker_pkg SHALL hold:
- the loader_state_e enum;
- TINKER_RESET_PC = 64'h2000;
- TINKER_MEM_BYTES = 524288;
- WORD_BYTES = 8.
REQ-028 The byte packer (buffer, count and the full/last flag) SHALL be the single sub-module tinker_byte_packer; everything else SHALL be flat.

Verification
REQ-029 Stream bytes 01..08 with in_last on 08, mem_ready tied 1 -> one write, addr 64'h2000, wdata 64'h0807060504030201, then done=1 and core_reset=0.
REQ-030 Stream 10 bytes 00..09 with in_last on 09 -> writes {2000: 0706050403020100} and {2008: 0000000000000908}, then DONE.
REQ-031 Hold mem_ready=0 for 5 cycles during WRITE -> mem_we, mem_addr and mem_wdata stay stable and in_ready stays 0; exactly one write on release.
REQ-032 Set MEM_BYTES=64'h2008 and stream 9 bytes -> first word written, then error=1 with core_reset=1 and no second write; a following start re-arms at 64'h2000.
REQ-033 Assert reset=0 mid-WRITE, then release and pulse start -> mem_we=0 at once, state IDLE then COLLECT, address 64'h2000.
REQ-034 With LOADER_CSUM_EN, stream 01 02 03 then checksum 06 -> write of 64'h030201 and DONE; with checksum 07 -> ERROR and no write.

Source files
------------

// File: rtl/tinker_prog_loader_pkg.sv
// Shared types and constants for the tinker program loader.
package tinker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [63:0] TINKER_RESET_PC  = 64'h2000;
  localparam logic [63:0] TINKER_MEM_BYTES = 64'd524288;
  localparam int unsigned WORD_BYTES       = 8;

endpackage

// File: rtl/tinker_prog_loader_if.sv
// Image byte stream and memory write port of the program loader.
interface tinker_prog_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  in_valid, in_data, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/tinker_prog_loader_byte_packer.sv
// Packs accepted bytes little-endian into one 64-bit word and remembers
// whether the word holds the final image byte.
module tinker_byte_packer
  import tinker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        store,
  input  logic        mark_last,
  input  logic [7:0]  data,
  output logic [63:0] buffer,
  output logic [3:0]  count,
  output logic        last_flag
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer    <= '0;
      count     <= '0;
      last_flag <= 1'b0;
    end else if (clear) begin
      buffer    <= '0;
      count     <= '0;
      last_flag <= 1'b0;
    end else begin
      if (store) begin
        buffer <= buffer | ({56'd0, data} << {count[2:0], 3'b000});
        count  <= count + 4'd1;
      end
      if (mark_last)
        last_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/tinker_prog_loader.sv
// Loads a byte-streamed program image into memory as 64-bit words, then
// releases the core from reset. Define LOADER_CSUM_EN for a trailing checksum byte.
module tinker_prog_loader
  import tinker_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = TINKER_RESET_PC,
  parameter logic [63:0] MEM_BYTES = TINKER_MEM_BYTES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  tinker_prog_loader_if.master        bus,
  output logic                        core_reset,
  output logic                        done,
  output logic                        error
);

  loader_state_e state;
  logic [63:0]   addr;
  logic          in_ready_q;
  logic          mem_we_q;

  logic [63:0]   buffer;
  logic [3:0]    count;
  logic          last_flag;

  logic accept, arm, commit, clear, store, word_end, overflow, last_slot;

  assign accept    = bus.in_valid && in_ready_q;
  assign arm       = start && (state == IDLE || state == DONE || state == ERROR);
  assign commit    = (state == WRITE) && bus.mem_ready;
  assign clear     = arm || commit;
  assign last_slot = (count == 4'(WORD_BYTES - 1));
  assign word_end  = accept && (bus.in_last || last_slot);
  // 65-bit compare so an address near the top of the range cannot wrap.
  assign overflow  = ({1'b0, addr} + 65'(WORD_BYTES)) > {1'b0, MEM_BYTES};

`ifdef LOADER_CSUM_EN
  logic [7:0] sum;
  logic       sum_ok;
  assign sum_ok = (sum == bus.in_data);
  // The checksum byte is never stored in the word.
  assign store  = accept && !bus.in_last;
`else
  assign store  = accept;
`endif

  tinker_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .store     (store),
    .mark_last (accept && bus.in_last),
    .data      (bus.in_data),
    .buffer    (buffer),
    .count     (count),
    .last_flag (last_flag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= BASE_ADDR;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= COLLECT;
            addr       <= BASE_ADDR;
            in_ready_q <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CSUM_EN
            sum        <= '0;
`endif
          end
        end
        COLLECT: begin
`ifdef LOADER_CSUM_EN
          if (store)
            sum <= sum + bus.in_data;
          if (word_end) begin
            in_ready_q <= 1'b0;
            if (bus.in_last && !sum_ok) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (bus.in_last && count == 4'd0) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else if (overflow) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state    <= WRITE;
              mem_we_q <= 1'b1;
            end
          end
`else
          if (word_end) begin
            in_ready_q <= 1'b0;
            if (overflow) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state    <= WRITE;
              mem_we_q <= 1'b1;
            end
          end
`endif
        end
        WRITE: begin
          if (bus.mem_ready) begin
            mem_we_q <= 1'b0;
            addr     <= addr + 64'(WORD_BYTES);
            if (last_flag) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state      <= COLLECT;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = buffer;

endmodule

// File: tb/tb_tinker_prog_loader.sv
// Directed bench for tinker_prog_loader; dut_b uses a tiny memory for the overflow case.
module tb_tinker_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b1;
  logic        core_reset_a, done_a, error_a;
  logic        core_reset_b, done_b, error_b;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned n_before;

  logic [63:0] wa_addr[$];
  logic [63:0] wa_data[$];
  logic [63:0] wb_addr[$];
  logic [63:0] wb_data[$];

  always #5 clk = ~clk;

  tinker_prog_loader_if ifa ();
  tinker_prog_loader_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifa.mem_ready = mem_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_last   = in_last;
  assign ifb.mem_ready = mem_ready;

  tinker_prog_loader #(.BASE_ADDR(64'h2000), .MEM_BYTES(64'd524288)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .bus        (ifa),
    .core_reset (core_reset_a),
    .done       (done_a),
    .error      (error_a)
  );

  tinker_prog_loader #(.BASE_ADDR(64'h2000), .MEM_BYTES(64'h2008)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .bus        (ifb),
    .core_reset (core_reset_b),
    .done       (done_b),
    .error      (error_b)
  );

  always @(posedge clk) begin
    if (ifa.mem_we && ifa.mem_ready) begin
      wa_addr.push_back(ifa.mem_addr);
      wa_data.push_back(ifa.mem_wdata);
    end
    if (ifb.mem_we && ifb.mem_ready) begin
      wb_addr.push_back(ifb.mem_addr);
      wb_data.push_back(ifb.mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit last);
    int unsigned budget;
    bit rdy;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      rdy = sel ? ifb.in_ready : ifa.in_ready;
      tick();
      if (rdy) break;
      budget++;
      if (budget > 40) begin
        total++;
        bad++;
        $error("FAIL send_timeout observed=no_ready expected=ready byte=%h", d);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd0);
    chk("rst_mem_we", 64'(ifa.mem_we), 64'd0);
    chk("rst_mem_addr", ifa.mem_addr, 64'h2000);
    chk("rst_mem_wdata", ifa.mem_wdata, 64'h0);
    chk("rst_core_reset", 64'(core_reset_a), 64'd1);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_error", 64'(error_a), 64'd0);
    chk("rst_b_core_reset", 64'(core_reset_b), 64'd1);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", 64'(ifa.in_ready), 64'd0);

`ifndef LOADER_CSUM_EN
    // Eight bytes, last on the eighth: one word then DONE
    mem_ready = 1'b1;
    pulse(1'b0);
    chk("arm_in_ready", 64'(ifa.in_ready), 64'd1);
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), i == 8);
    chk("w8_mem_we", 64'(ifa.mem_we), 64'd1);
    chk("w8_addr", ifa.mem_addr, 64'h2000);
    chk("w8_wdata", ifa.mem_wdata, 64'h0807060504030201);
    chk("w8_in_ready", 64'(ifa.in_ready), 64'd0);
    tick();
    chk("w8_done", 64'(done_a), 64'd1);
    chk("w8_core_reset", 64'(core_reset_a), 64'd0);
    chk("w8_mem_we_off", 64'(ifa.mem_we), 64'd0);
    chk("w8_count", 64'(wa_addr.size()), 64'd1);
    chk("w8_log_addr", wa_addr[0], 64'h2000);
    chk("w8_log_data", wa_data[0], 64'h0807060504030201);

    // Ten bytes: full word then a zero-padded partial word
    pulse(1'b0);
    chk("w10_core_reset", 64'(core_reset_a), 64'd1);
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 1'b0);
    chk("w10a_wdata", ifa.mem_wdata, 64'h0706050403020100);
    chk("w10a_addr", ifa.mem_addr, 64'h2000);
    tick();
    chk("w10_collect_ready", 64'(ifa.in_ready), 64'd1);
    send(1'b0, 8'h08, 1'b0);
    send(1'b0, 8'h09, 1'b1);
    chk("w10b_addr", ifa.mem_addr, 64'h2008);
    chk("w10b_wdata", ifa.mem_wdata, 64'h0000000000000908);
    tick();
    chk("w10_done", 64'(done_a), 64'd1);
    chk("w10_count", 64'(wa_addr.size()), 64'd3);
    chk("w10_log_data1", wa_data[1], 64'h0706050403020100);
    chk("w10_log_addr2", wa_addr[2], 64'h2008);
    chk("w10_log_data2", wa_data[2], 64'h0000000000000908);

    // Overflow on the second word of a 9-byte image (memory ends at 0x2008)
    pulse(1'b1);
    for (int i = 0; i < 9; i++) send(1'b1, 8'(8'h11 + i), i == 8);
    chk("ovf_error", 64'(error_b), 64'd1);
    chk("ovf_core_reset", 64'(core_reset_b), 64'd1);
    chk("ovf_mem_we", 64'(ifb.mem_we), 64'd0);
    chk("ovf_in_ready", 64'(ifb.in_ready), 64'd0);
    tick();
    tick();
    chk("ovf_count", 64'(wb_addr.size()), 64'd1);
    chk("ovf_log_addr", wb_addr[0], 64'h2000);
    chk("ovf_log_data", wb_data[0], 64'h1817161514131211);
    pulse(1'b1);
    chk("ovf_rearm_ready", 64'(ifb.in_ready), 64'd1);
    chk("ovf_rearm_addr", ifb.mem_addr, 64'h2000);
    chk("ovf_rearm_error", 64'(error_b), 64'd0);
`else
    // Checksum image: 01 02 03 + matching 06
    mem_ready = 1'b1;
    pulse(1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    send(1'b0, 8'h06, 1'b1);
    chk("cs_mem_we", 64'(ifa.mem_we), 64'd1);
    chk("cs_wdata", ifa.mem_wdata, 64'h0000000000030201);
    chk("cs_addr", ifa.mem_addr, 64'h2000);
    tick();
    chk("cs_done", 64'(done_a), 64'd1);
    chk("cs_count", 64'(wa_addr.size()), 64'd1);

    // Bad checksum 07: ERROR and no write
    pulse(1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    send(1'b0, 8'h07, 1'b1);
    chk("csbad_error", 64'(error_a), 64'd1);
    chk("csbad_mem_we", 64'(ifa.mem_we), 64'd0);
    tick();
    chk("csbad_count", 64'(wa_addr.size()), 64'd1);
    chk("csbad_core_reset", 64'(core_reset_a), 64'd1);

    // Full word then checksum alone: straight to DONE, no extra write
    pulse(1'b0);
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), 1'b0);
    chk("csfull_wdata", ifa.mem_wdata, 64'h0807060504030201);
    tick();
    send(1'b0, 8'h24, 1'b1);
    chk("csfull_done", 64'(done_a), 64'd1);
    chk("csfull_mem_we", 64'(ifa.mem_we), 64'd0);
    tick();
    chk("csfull_count", 64'(wa_addr.size()), 64'd2);
`endif

    // Backpressure: WRITE held for five cycles
    mem_ready = 1'b0;
    pulse(1'b0);
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(8'ha0 + i), 1'b0);
    n_before = wa_addr.size();
    chk("bp_mem_we0", 64'(ifa.mem_we), 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_mem_we", 64'(ifa.mem_we), 64'd1);
      chk("bp_addr", ifa.mem_addr, 64'h2000);
      chk("bp_wdata", ifa.mem_wdata, 64'ha8a7a6a5a4a3a2a1);
      chk("bp_in_ready", 64'(ifa.in_ready), 64'd0);
    end
    chk("bp_no_write", 64'(wa_addr.size()), 64'(n_before));
    mem_ready = 1'b1;
    tick();
    chk("bp_one_write", 64'(wa_addr.size()), 64'(n_before + 1));
    chk("bp_log_data", wa_data[n_before], 64'ha8a7a6a5a4a3a2a1);
    chk("bp_release_we", 64'(ifa.mem_we), 64'd0);
    chk("bp_release_ready", 64'(ifa.in_ready), 64'd1);

    // Reset in the middle of a held WRITE
    mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(8'hb0 + i), 1'b0);
    chk("mr_mem_we", 64'(ifa.mem_we), 64'd1);
    chk("mr_addr", ifa.mem_addr, 64'h2008);
    n_before = wa_addr.size();
    reset = 1'b0;
    #1;
    chk("mr_we_drop", 64'(ifa.mem_we), 64'd0);
    chk("mr_addr_rst", ifa.mem_addr, 64'h2000);
    chk("mr_wdata_rst", ifa.mem_wdata, 64'h0);
    chk("mr_core_reset", 64'(core_reset_a), 64'd1);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("mr_idle_ready", 64'(ifa.in_ready), 64'd0);
    chk("mr_idle_we", 64'(ifa.mem_we), 64'd0);
    chk("mr_no_write", 64'(wa_addr.size()), 64'(n_before));
    pulse(1'b0);
    chk("mr_rearm_ready", 64'(ifa.in_ready), 64'd1);
    chk("mr_rearm_addr", ifa.mem_addr, 64'h2000);
    chk("mr_rearm_wdata", ifa.mem_wdata, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
